mips_prog_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the pipelined MIPS32 core. It receives a framed byte stream (header, big-endian instruction words, checksum) over a valid/ready handshake. It writes each assembled word into instruction memory at consecutive addresses. It holds the core halted until a load completes with a good checksum, then releases it with a one-cycle start pulse so the core fetches from PC = 0.

---
 rtl/mips_pkg.sv | 7 +
 rtl/mips_byte_packer.sv | 30 +++
 rtl/mips_prog_loader.sv | 108 ++++++++++
 tb/tb_mips_prog_loader.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared loader state encoding and frame-format constants
package mips_pkg;
    typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
    localparam int HDR_LEN = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int CSUM_W = 8;
endpackage

// File: rtl/mips_byte_packer.sv
// mips_byte_packer: assembles big-endian bytes into 32-bit words
module mips_byte_packer
    import mips_pkg::*;
(
    input  logic        clk1,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_valid
);
    logic [1:0]  cnt;
    logic [23:0] sh;
    // word is presented combinationally with the incoming byte so the top can register it on the 4th accept
    assign word = {sh, data};
    assign word_valid = en && cnt == 2'(BYTES_PER_WORD - 1);
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sh <= '0;
        end else if (clr) begin
            cnt <= '0;
            sh <= '0;
        end else if (en) begin
            cnt <= cnt + 2'd1;
            sh <= word[23:0];
        end
    end
endmodule

// File: rtl/mips_prog_loader.sv
// mips_prog_loader: framed byte-stream loader into instruction memory;
// holds the core until a load completes with a good checksum
module mips_prog_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int MEM_BASE = 0
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              cpu_start,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int MAX_WORDS = (1 << ADDR_W) - MEM_BASE;
    state_t              state;
    logic [15:0]         n;
    logic [15:0]         idx;
    logic [CSUM_W-1:0]   csum;
    logic [15:0]         n_full;
    logic                acc;
    logic                go;
    logic                word_valid;
    logic [31:0]         word;
    assign in_ready = state inside {S_HDR0, S_HDR1, S_DATA, S_CSUM};
    assign busy = in_ready;
    assign go = start && !busy;
    assign acc = in_valid && in_ready;
    assign n_full = {n[15:8], in_data};
    mips_byte_packer u_packer (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .clr       (go),
        .en        (acc && state == S_DATA),
        .data      (in_data),
        .word      (word),
        .word_valid(word_valid)
    );
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            n <= '0;
            idx <= '0;
            csum <= '0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            cpu_hold <= 1'b1;
            cpu_start <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            cpu_start <= 1'b0;
            if (go) begin
                state <= S_HDR0;
                done <= 1'b0;
                err <= 1'b0;
                cpu_hold <= 1'b1;
                idx <= '0;
                csum <= '0;
            end else if (acc) begin
                csum <= csum ^ in_data;
                case (state)
                    S_HDR0: begin
                        n[15:8] <= in_data;
                        state <= S_HDR1;
                    end
                    S_HDR1: begin
                        n[7:0] <= in_data;
                        if (32'(n_full) > 32'(MAX_WORDS)) begin
                            state <= S_ERR;
                            err <= 1'b1;
                        end else begin
                            state <= n_full == 16'd0 ? S_CSUM : S_DATA;
                        end
                    end
                    S_DATA: if (word_valid) begin
                        mem_we <= 1'b1;
                        mem_addr <= ADDR_W'(MEM_BASE) + idx[ADDR_W-1:0];
                        mem_wdata <= word;
                        idx <= idx + 16'd1;
                        if (idx == n - 16'd1) state <= S_CSUM;
                    end
                    S_CSUM: if (in_data == csum) begin
                        state <= S_DONE;
                        done <= 1'b1;
                        cpu_start <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state <= S_ERR;
                        err <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mips_prog_loader.sv
// tb_mips_prog_loader: directed scenarios for the program loader
module tb_mips_prog_loader;
    logic        clk1 = 0;
    logic        rst_n = 1;
    logic        start = 0;
    logic        in_valid = 0;
    logic [7:0]  in_data = 0;
    logic        in_ready, mem_we, cpu_hold, cpu_start, busy, done, err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    int checks = 0;
    int fails = 0;
    logic [9:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int pulses = 0;
    logic [31:0] prog [9] = '{32'h2801000a, 32'h28020014, 32'h00221820, 32'hac030000, 32'h8c040000,
                              32'h10800002, 32'h2084ffff, 32'h08000006, 32'hfc000000};

    mips_prog_loader #(.ADDR_W(10), .MEM_BASE(0)) dut (
        .clk1(clk1), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .cpu_start(cpu_start), .busy(busy), .done(done), .err(err)
    );

    always #5 clk1 = ~clk1;

    always @(negedge clk1) begin
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
        end
        if (cpu_start) pulses++;
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        pulses = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        if (gaps) repeat ($urandom_range(0, 2)) begin
            in_data = 8'($urandom);
            tick();
        end
        in_valid = 1;
        in_data = b;
        tick();
        in_valid = 0;
        in_data = 8'($urandom);
    endtask

    task automatic send_frame(input int nw, input bit bad, input bit gaps, input bit mid_start);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'(nw >> 8) ^ 8'(nw);
        send_byte(8'(nw >> 8), gaps);
        send_byte(8'(nw), gaps);
        for (int i = 0; i < nw; i++) begin
            for (int j = 0; j < 4; j++) begin
                b = prog[i][31-8*j -: 8];
                cs ^= b;
                if (mid_start && i == 4 && j == 2) pulse_start();
                send_byte(b, gaps);
            end
        end
        send_byte(bad ? ~cs : cs, gaps);
    endtask

    task automatic check_writes(input string name, input int nw);
        checks++; if (wa_q.size() != nw) begin fails++; $display("FAIL %s_count: got %0d writes, expected %0d", name, wa_q.size(), nw); end
        for (int i = 0; i < nw && i < wa_q.size(); i++) begin
            checks++;
            if (wa_q[i] !== 10'(i) || wd_q[i] !== prog[i]) begin
                fails++;
                $display("FAIL %s_write%0d: got addr %0d data %h, expected addr %0d data %h", name, i, wa_q[i], wd_q[i], i, prog[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        #1;
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if (mem_addr !== 10'd0) begin fails++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        checks++; if (mem_wdata !== 32'd0) begin fails++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
        checks++; if (cpu_hold !== 1'b1) begin fails++; $display("FAIL reset_cpu_hold: got %b expected 1", cpu_hold); end
        checks++; if (cpu_start !== 1'b0) begin fails++; $display("FAIL reset_cpu_start: got %b expected 0", cpu_start); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_nominal();
        clear_log();
        pulse_start();
        checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin fails++; $display("FAIL nom_start: got busy %b in_ready %b expected 1 1", busy, in_ready); end
        send_frame(9, 0, 0, 0);
        checks++; if (done !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL nom_done: got done %b err %b expected 1 0", done, err); end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL nom_idle: got busy %b in_ready %b expected 0 0", busy, in_ready); end
        checks++; if (cpu_start !== 1'b1 || cpu_hold !== 1'b0) begin fails++; $display("FAIL nom_release: got cpu_start %b cpu_hold %b expected 1 0", cpu_start, cpu_hold); end
        tick();
        checks++; if (cpu_start !== 1'b0 || cpu_hold !== 1'b0) begin fails++; $display("FAIL nom_pulse_end: got cpu_start %b cpu_hold %b expected 0 0", cpu_start, cpu_hold); end
        check_writes("nom", 9);
        checks++; if (pulses != 1) begin fails++; $display("FAIL nom_pulses: got %0d cpu_start cycles expected 1", pulses); end
    endtask

    task automatic test_bad_csum();
        clear_log();
        pulse_start();
        checks++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL bad_restart: got cpu_hold %b done %b expected 1 0", cpu_hold, done); end
        send_frame(9, 1, 0, 0);
        tick();
        checks++; if (err !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL bad_flags: got err %b done %b expected 1 0", err, done); end
        checks++; if (cpu_hold !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL bad_hold: got cpu_hold %b busy %b expected 1 0", cpu_hold, busy); end
        check_writes("bad", 9);
        checks++; if (pulses != 0) begin fails++; $display("FAIL bad_pulses: got %0d cpu_start cycles expected 0", pulses); end
    endtask

    task automatic test_zero_len();
        clear_log();
        pulse_start();
        send_frame(0, 0, 0, 0);
        checks++; if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL zero_done: got done %b err %b busy %b expected 1 0 0", done, err, busy); end
        tick();
        checks++; if (wa_q.size() != 0 || pulses != 1) begin fails++; $display("FAIL zero_log: got %0d writes %0d pulses expected 0 1", wa_q.size(), pulses); end
    endtask

    task automatic test_too_long();
        clear_log();
        pulse_start();
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        checks++; if (err !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL long_err: got err %b done %b expected 1 0", err, done); end
        checks++; if (in_ready !== 1'b0 || busy !== 1'b0 || cpu_hold !== 1'b1) begin fails++; $display("FAIL long_state: got in_ready %b busy %b cpu_hold %b expected 0 0 1", in_ready, busy, cpu_hold); end
        send_byte(8'h55, 0);
        checks++; if (wa_q.size() != 0 || pulses != 0) begin fails++; $display("FAIL long_log: got %0d writes %0d pulses expected 0 0", wa_q.size(), pulses); end
    endtask

    task automatic test_gaps_mid_start();
        clear_log();
        pulse_start();
        send_frame(9, 0, 1, 1);
        checks++; if (done !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL gap_done: got done %b err %b expected 1 0", done, err); end
        tick();
        check_writes("gap", 9);
        checks++; if (pulses != 1 || cpu_hold !== 1'b0) begin fails++; $display("FAIL gap_release: got %0d pulses cpu_hold %b expected 1 0", pulses, cpu_hold); end
    endtask

    task automatic test_reset_mid();
        clear_log();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h09, 0);
        for (int j = 0; j < 4; j++) send_byte(prog[0][31-8*j -: 8], 0);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 10'd0 || mem_wdata !== 32'h2801000a) begin fails++; $display("FAIL lat_write: got we %b addr %0d data %h expected 1 0 2801000a", mem_we, mem_addr, mem_wdata); end
        send_byte(prog[1][31:24], 0);
        checks++; if (mem_we !== 1'b0 || mem_addr !== 10'd0 || mem_wdata !== 32'h2801000a) begin fails++; $display("FAIL lat_hold: got we %b addr %0d data %h expected 0 0 2801000a", mem_we, mem_addr, mem_wdata); end
        for (int j = 1; j < 4; j++) send_byte(prog[1][31-8*j -: 8], 0);
        for (int j = 0; j < 4; j++) send_byte(prog[2][31-8*j -: 8], 0);
        send_byte(prog[3][31:24], 0);
        in_valid = 1;
        in_data = prog[3][23:16];
        #2;
        rst_n = 0;
        #1;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || cpu_hold !== 1'b1) begin fails++; $display("FAIL rst_ctrl: got busy %b in_ready %b cpu_hold %b expected 0 0 1", busy, in_ready, cpu_hold); end
        checks++; if (mem_addr !== 10'd0 || mem_wdata !== 32'd0 || mem_we !== 1'b0) begin fails++; $display("FAIL rst_mem: got we %b addr %0d data %h expected 0 0 0", mem_we, mem_addr, mem_wdata); end
        checks++; if (wa_q.size() != 3) begin fails++; $display("FAIL rst_partial: got %0d writes expected 3", wa_q.size()); end
        in_valid = 0;
        tick();
        rst_n = 1;
        tick();
        clear_log();
        pulse_start();
        send_frame(9, 0, 0, 0);
        checks++; if (done !== 1'b1 || cpu_start !== 1'b1) begin fails++; $display("FAIL rst_reload: got done %b cpu_start %b expected 1 1", done, cpu_start); end
        tick();
        check_writes("reload", 9);
    endtask

    initial begin
        #2;
        test_reset();
        test_nominal();
        test_bad_csum();
        test_zero_len();
        test_too_long();
        test_gaps_mid_start();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
